dsp_mac_seq: RTL and testbench

Job sequencer for the DSP48A1 slice in multiply-accumulate mode. It accepts a job length, streams operand pairs into the slice's A/B ports, and drives OPMODE and clock enables so that P holds Σ a·b over the job. It then captures P and presents the result on a valid/ready port. It sits between a sample producer and the DSP48A1 top, and is the only driver of the slice's A, B, OPMODE and CE inputs.

---
 rtl/dsp_seq_pkg.sv | 42 ++++
 rtl/dsp_mac_seq_if.sv | 27 ++
 rtl/mac_tag_pipe.sv | 41 ++++
 rtl/dsp_mac_seq.sv | 134 +++++++++++++
 tb/tb_dsp_mac_seq.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared types and OPMODE constants for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } seq_state_e;

  // Kind of work a pipeline slot carries; LAST rides alongside as a flag
  typedef enum logic [1:0] {
    SLOT_NOP,
    SLOT_FIRST,
    SLOT_ACC
  } slot_kind_e;

  typedef struct packed {
    logic       last;
    slot_kind_e kind;
  } slot_tag_t;

  localparam logic [7:0] OPM_FIRST   = 8'h01;
  localparam logic [7:0] OPM_ACC     = 8'h09;
  localparam logic [7:0] OPM_NOP     = 8'h08;
  localparam int         OPM_SUB_BIT = 7;
  localparam int         P_W         = 48;

  // Translate a slot kind into the slice OPMODE; subtraction only touches
  // slots that actually feed the multiplier result into the adder
  function automatic logic [7:0] slot_opmode(slot_kind_e kind, logic sub);
    logic [7:0] opm;
    case (kind)
      SLOT_FIRST: opm = OPM_FIRST;
      SLOT_ACC:   opm = OPM_ACC;
      default:    opm = OPM_NOP;
    endcase
    if (sub && (kind != SLOT_NOP)) opm[OPM_SUB_BIT] = 1'b1;
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: operand stream into the sequencer and result stream out of it.
// master = producer/consumer side, slave = the sequencer.
interface dsp_mac_seq_if #(
  parameter int WIDTH_A = 18,
  parameter int WIDTH_B = 18
);
  import dsp_seq_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [WIDTH_A-1:0] s_a;
  logic [WIDTH_B-1:0] s_b;
  logic               res_valid;
  logic               res_ready;
  logic [P_W-1:0]     res_data;

  modport master (
    output s_valid, s_a, s_b, res_ready,
    input  s_ready, res_valid, res_data
  );

  modport slave (
    input  s_valid, s_a, s_b, res_ready,
    output s_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe: delay line for slot tags. The slot kind is tapped OPM_DLY
// stages in to choose OPMODE; the LAST flag runs the full PIPE_LAT stages and
// is reported one cycle after it leaves the tail, when P holds the final sum.
module mac_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  slot_tag_t  tag_i,
  output slot_kind_e tap_kind_o,
  output logic       last_exit_o
);

  // Only the kind up to the OPMODE tap is ever looked at, so the kind chain
  // stops there while the LAST chain runs the full latency
  slot_kind_e kind_q [0:OPM_DLY];
  logic       last_q [0:PIPE_LAT-1];
  logic       last_exit_q;

  // Shift every cycle; reset empties the pipe so a stale job cannot leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= OPM_DLY; i++) kind_q[i] <= SLOT_NOP;
      for (int i = 0; i < PIPE_LAT; i++) last_q[i] <= 1'b0;
      last_exit_q <= 1'b0;
    end else begin
      kind_q[0] <= tag_i.kind;
      for (int i = 1; i <= OPM_DLY; i++) kind_q[i] <= kind_q[i-1];
      last_q[0] <= tag_i.last;
      for (int i = 1; i < PIPE_LAT; i++) last_q[i] <= last_q[i-1];
      last_exit_q <= last_q[PIPE_LAT-1];
    end
  end

  assign tap_kind_o  = kind_q[OPM_DLY];
  assign last_exit_o = last_exit_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: job sequencer running a DSP48A1 slice as a multiply-accumulator.
// Takes a job length, streams operand pairs to the slice, steers OPMODE so P
// ends up holding the sum of products, then offers P on a valid/ready port.
// Optional: define MAC_SUB_EN to add start_sub_i; a job started with it set
// produces the negated sum.
module dsp_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int WIDTH_A  = 18,
  parameter int WIDTH_B  = 18,
  parameter int LEN_W    = 8,
  parameter int OPM_DLY  = 2,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   len_i,
`ifdef MAC_SUB_EN
  input  logic               start_sub_i,
`endif
  output logic               busy_o,
  dsp_mac_seq_if.slave       bus,
  output logic [WIDTH_A-1:0] dsp_a_o,
  output logic [WIDTH_B-1:0] dsp_b_o,
  output logic [7:0]         dsp_opmode_o,
  output logic               dsp_ce_o,
  input  logic [P_W-1:0]     dsp_p_i
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_e         state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic               first_q;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic [P_W-1:0]     res_q;
`ifdef MAC_SUB_EN
  logic               sub_q;
`endif
  logic               sub_sel;
  logic               hs;
  slot_tag_t          issue_tag;
  slot_kind_e         tap_kind;
  logic               last_exit;

`ifdef MAC_SUB_EN
  assign sub_sel = sub_q;
`else
  assign sub_sel = 1'b0;
`endif

  assign hs = (state_q == ST_RUN) && bus.s_valid;

  // Tag the slot issued this cycle: a product (first or accumulate) on a
  // handshake, otherwise a NOP that leaves P untouched
  always_comb begin
    issue_tag      = '{last: 1'b0, kind: SLOT_NOP};
    if (hs) begin
      issue_tag.kind = first_q ? SLOT_FIRST : SLOT_ACC;
      issue_tag.last = (remaining_q == LEN_ONE);
    end
  end

  mac_tag_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .OPM_DLY  (OPM_DLY)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .tag_i       (issue_tag),
    .tap_kind_o  (tap_kind),
    .last_exit_o (last_exit)
  );

  // Job control: load length, count handshakes down, wait for the last
  // product to reach P, then hold the captured sum until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
`ifdef MAC_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && (len_i != '0)) begin
            state_q     <= ST_RUN;
            remaining_q <= len_i;
            first_q     <= 1'b1;
`ifdef MAC_SUB_EN
            sub_q       <= start_sub_i;
`endif
          end
        end
        ST_RUN: begin
          if (hs) begin
            a_q         <= bus.s_a;
            b_q         <= bus.s_b;
            first_q     <= 1'b0;
            remaining_q <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_exit) begin
            res_q   <= dsp_p_i;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign bus.s_ready   = (state_q == ST_RUN);
  assign bus.res_valid = (state_q == ST_HOLD);
  assign bus.res_data  = res_q;
  assign dsp_a_o       = a_q;
  assign dsp_b_o       = b_q;
  assign dsp_ce_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign dsp_opmode_o  = slot_opmode(tap_kind, sub_sel);

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: self-checking bench for dsp_mac_seq. A behavioural DSP48A1
// stand-in closes the loop on P; expected sums, OPMODE per cycle and result
// latency come from a job-level reference computed in the bench.
// Build with MAC_SUB_EN defined to also exercise the subtract job.
`timescale 1ns/1ps
module tb_dsp_mac_seq;

  localparam int WA   = 18;
  localparam int WB   = 18;
  localparam int LW   = 8;
  localparam int LOGN = 8192;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len   = '0;
`ifdef MAC_SUB_EN
  logic          startSub = 1'b0;
`endif
  logic          busy;
  logic [WA-1:0] dspA;
  logic [WB-1:0] dspB;
  logic [7:0]    dspOpmode;
  logic          dspCe;
  logic [47:0]   dspP;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] opLog [0:LOGN-1];
  logic       ceLog [0:LOGN-1];

  logic signed [WA-1:0] qa[$];
  logic signed [WB-1:0] qb[$];

  dsp_mac_seq_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

  dsp_mac_seq #(
    .WIDTH_A(WA), .WIDTH_B(WB), .LEN_W(LW), .OPM_DLY(2), .PIPE_LAT(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .len_i        (len),
`ifdef MAC_SUB_EN
    .start_sub_i  (startSub),
`endif
    .busy_o       (busy),
    .bus          (bus),
    .dsp_a_o      (dspA),
    .dsp_b_o      (dspB),
    .dsp_opmode_o (dspOpmode),
    .dsp_ce_o     (dspCe),
    .dsp_p_i      (dspP)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle k runs from the k-th rising edge to the next one
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slice: A/B register, M register, P updated from current OPMODE
  logic signed [WA-1:0] ar   = '0;
  logic signed [WB-1:0] br   = '0;
  logic [47:0]          mReg = '0;
  logic [47:0]          pReg = 48'h0000_dead_beef;
  assign dspP = pReg;

  function automatic logic [47:0] sliceP(input logic [7:0] opm, input logic [47:0] m,
                                         input logic [47:0] p);
    logic [47:0] x;
    logic [47:0] z;
    x = (opm[1:0] == 2'b01) ? m : 48'd0;
    z = (opm[3:2] == 2'b10) ? p : 48'd0;
    return opm[7] ? (z - x) : (z + x);
  endfunction

  // Slice model advances only while the sequencer enables it
  always @(posedge clk) begin
    if (dspCe) begin
      ar   <= dspA;
      br   <= dspB;
      mReg <= 48'(longint'(ar) * longint'(br));
      pReg <= sliceP(dspOpmode, mReg, pReg);
    end
  end

  // Record what the sequencer presented to the slice in every cycle
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      opLog[cyc] = dspOpmode;
      ceLog[cyc] = dspCe;
    end
  end

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"},      busy,          0);
    checkOutput({tag, " s_ready"},   bus.s_ready,   0);
    checkOutput({tag, " res_valid"}, bus.res_valid, 0);
    checkOutput({tag, " res_data"},  bus.res_data,  0);
    checkOutput({tag, " dsp_a"},     dspA,          0);
    checkOutput({tag, " dsp_b"},     dspB,          0);
    checkOutput({tag, " opmode"},    dspOpmode,     8'h08);
    checkOutput({tag, " ce"},        dspCe,         0);
  endtask

  task automatic recoverDut();
    start = 1'b0; bus.s_valid = 1'b0; bus.res_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run one job from qa/qb. Called at a falling edge with the DUT idle.
  // gapMode: 0 = valid every cycle, 1 = alternate, 2 = random ~30% gaps
  task automatic applyStimulus(input int n, input int gapMode, input int holdCycles,
                               input bit sub, input bit pokeStart, input string name);
    longint      expSum;
    logic [47:0] expP;
    int          hsCyc[$];
    int          idx, budget, startCyc, tLast, tRes, w, bad, badCe;
    logic [47:0] heldData;
    logic        v;

    expSum = 0;
    for (int i = 0; i < n; i++) expSum += longint'(qa[i]) * longint'(qb[i]);
    if (sub) expSum = -expSum;
    expP = expSum[47:0];

    startCyc = cyc;
    start = 1'b1;
    len   = LW'(n);
`ifdef MAC_SUB_EN
    startSub = sub;
`endif
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    checkOutput({name, " busy"}, busy, 1);

    idx = 0; budget = 0; bad = 0;
    while (idx < n && budget < n * 20 + 50) begin
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = ($urandom_range(0, 99) >= 30);
      endcase
      bus.s_valid = v;
      bus.s_a     = qa[idx];
      bus.s_b     = qb[idx];
      if (pokeStart) begin
        start = 1'b1;
        len   = LW'($urandom_range(1, 255));
      end
      if (!bus.s_ready) bad++;
      if (v && bus.s_ready) begin
        hsCyc.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      budget++;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
    len   = '0;
    checkOutput({name, " pairs taken"}, idx, n);
    if (idx < n) begin
      recoverDut();
      return;
    end
    checkOutput({name, " s_ready in RUN"}, bad, 0);
    tLast = hsCyc[n-1];
    checkOutput({name, " s_ready fall"}, bus.s_ready, 0);

    w = 0;
    while (!bus.res_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    tRes = cyc;
    checkOutput({name, " res latency"}, tRes, tLast + 5);
    if (!bus.res_valid) begin
      recoverDut();
      return;
    end
    checkOutput({name, " res_data"}, bus.res_data, expP);
    checkOutput({name, " ce in HOLD"}, dspCe, 0);

    // OPMODE and CE over the whole job window against the slot schedule
    bad = 0; badCe = 0;
    for (int c = startCyc + 1; c < tRes; c++) begin
      logic [7:0] e;
      e = 8'h08;
      for (int i = 0; i < n; i++)
        if (hsCyc[i] + 3 == c) e = (i == 0) ? (sub ? 8'h81 : 8'h01) : (sub ? 8'h89 : 8'h09);
      if (c < LOGN) begin
        if (opLog[c] !== e) bad++;
        if (ceLog[c] !== 1'b1) badCe++;
      end
    end
    checkOutput({name, " opmode schedule"}, bad, 0);
    checkOutput({name, " ce window"}, badCe, 0);
    for (int i = 0; i < n && i < 4; i++)
      if (hsCyc[i] + 3 < LOGN)
        checkOutput({name, " product opmode"}, opLog[hsCyc[i] + 3],
                    (i == 0) ? (sub ? 8'h81 : 8'h01) : (sub ? 8'h89 : 8'h09));

    heldData = bus.res_data;
    if (holdCycles > 0) begin
      bad = 0;
      for (int k = 0; k < holdCycles; k++) begin
        start = 1'b1;
        len   = 8'd5;
        @(negedge clk);
        if (bus.res_data !== heldData || dspCe !== 1'b0 || bus.res_valid !== 1'b1 ||
            busy !== 1'b1 || dspOpmode !== 8'h08) bad++;
      end
      checkOutput({name, " hold stable"}, bad, 0);
    end
    start = 1'b0;
    len   = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput({name, " idle after take"}, busy, 0);
  endtask

  // Hard stop in case anything stalls beyond every local bound
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios, then randomized jobs, then the summary
  initial begin
    int bad;
    int n;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back job with starts poked while busy
    qa = {18'sd2, 18'sd4, -18'sd1};
    qb = {18'sd3, 18'sd5, 18'sd7};
    applyStimulus(3, 0, 0, 1'b0, 1'b1, "job3");

    // Same job with one-cycle gaps and a long stall on res_ready
    applyStimulus(3, 1, 10, 1'b0, 1'b0, "gap3");

    // Zero-length request must not start anything
    start = 1'b1;
    len   = '0;
    bad   = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || dspCe !== 1'b0) bad++;
    end
    start = 1'b0;
    checkOutput("len0 ignored", bad, 0);

    // Reset in the middle of a four-pair job after one pair
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    bus.s_valid = 1'b1; bus.s_a = 18'sd2; bus.s_b = 18'sd3;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset opmode", dspOpmode, 8'h01);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midrun reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = {18'sd6};
    qb = {18'sd7};
    applyStimulus(1, 0, 2, 1'b0, 1'b0, "after reset");

    // Randomized jobs with random gaps, stalls and start pokes
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 10);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(18'($urandom));
        qb.push_back(18'($urandom));
      end
      applyStimulus(n, 2, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), "rand");
    end

    // Longest job the length field allows
    qa.delete(); qb.delete();
    for (int i = 0; i < 255; i++) begin
      qa.push_back(18'($urandom));
      qb.push_back(18'($urandom));
    end
    applyStimulus(255, 0, 0, 1'b0, 1'b0, "len255");

`ifdef MAC_SUB_EN
    qa = {18'sd3, 18'sd2};
    qb = {18'sd3, 18'sd5};
    applyStimulus(2, 0, 1, 1'b1, 1'b0, "sub");
    startSub = 1'b0;
    qa = {18'sd6};
    qb = {18'sd7};
    applyStimulus(1, 0, 0, 1'b0, 1'b0, "add after sub");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
